// File: rtl/instr_decode_pipe.sv
// rtl/instr_decode_pipe.sv - handshaked instruction field decoder; optional skid buffer under DECODE_SKID_EN
module instr_decode_pipe #(
  parameter int INSTR_W = 32,
  parameter int REG_W   = 6,
  parameter int IMM_W   = 16,
  parameter int MADDR_W = 10,
  parameter int TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         flag,
  output logic [3:0]         oper,
  output logic [REG_W-1:0]   rega,
  output logic [REG_W-1:0]   regb,
  output logic [IMM_W-1:0]   intermed,
  output logic [1:0]         mem_op,
  output logic [MADDR_W-1:0] mem_addr,
  output logic               illegal,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int T = INSTR_W - 1;

  typedef struct packed {
    logic [1:0]         flag;
    logic [3:0]         oper;
    logic [REG_W-1:0]   rega;
    logic [REG_W-1:0]   regb;
    logic [IMM_W-1:0]   intermed;
    logic [1:0]         mem_op;
    logic [MADDR_W-1:0] mem_addr;
    logic               illegal;
    logic [TAG_W-1:0]   tag;
  } res_t;

  // Every format must fit inside the instruction word.
  if ((INSTR_W < 4 + MADDR_W + IMM_W) || (INSTR_W < 6 + REG_W + IMM_W) ||
      (INSTR_W < 4 + REG_W + MADDR_W)) begin : g_param_check
    $error("instr_decode_pipe: INSTR_W too small for the field layout");
  end

  res_t dec;
  res_t out_q, out_d;
  logic out_valid_q, out_valid_d;
  logic accept;

  // Low bits below the widest format are don't-care.
  logic unused_instr_bits;
  assign unused_instr_bits = ^in_instr;

  // Decode straight from the current word; unlisted fields stay zero.
  always_comb begin
    dec      = '0;
    dec.tag  = in_tag;
    dec.flag = in_instr[T -: 2];
    case (dec.flag)
      2'd1: begin
        dec.oper = in_instr[T-2 -: 4];
        dec.rega = in_instr[T-6 -: REG_W];
        dec.regb = in_instr[T-6-REG_W -: REG_W];
      end
      2'd2: begin
        dec.oper = in_instr[T-2 -: 4];
        if (dec.oper == 4'd2) begin
          dec.rega = in_instr[T-6 -: REG_W];
          dec.regb = in_instr[T-6-REG_W -: REG_W];
        end else if (dec.oper == 4'd3) begin
          dec.rega     = in_instr[T-6 -: REG_W];
          dec.intermed = in_instr[T-6-REG_W -: IMM_W];
        end else begin
          dec.illegal = 1'b1;
        end
      end
      2'd3: begin
        dec.mem_op = in_instr[T-2 -: 2];
        if ((dec.mem_op == 2'd1) || (dec.mem_op == 2'd2)) begin
          dec.rega     = in_instr[T-4 -: REG_W];
          dec.mem_addr = in_instr[T-4-REG_W -: MADDR_W];
        end else begin
          dec.mem_addr = in_instr[T-4 -: MADDR_W];
          dec.intermed = in_instr[T-4-MADDR_W -: IMM_W];
        end
      end
      default: ;
    endcase
  end

`ifdef DECODE_SKID_EN
  res_t       skid_q [2];
  res_t       skid_d [2];
  logic [1:0] skid_cnt_q, skid_cnt_d;
  logic       in_ready_q, in_ready_d;
  logic       out_free;

  assign in_ready = in_ready_q & ~flush & ~rst;
  assign accept   = in_valid & in_ready;

  // Output register refills from the skid head first so order is kept.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    skid_d      = skid_q;
    skid_cnt_d  = skid_cnt_q;
    out_free    = ~out_valid_q | out_ready;
    if (flush) begin
      out_d       = '0;
      out_valid_d = 1'b0;
      skid_cnt_d  = 2'd0;
    end else if (out_free && (skid_cnt_q != 2'd0)) begin
      out_d       = skid_q[0];
      out_valid_d = 1'b1;
      skid_d[0]   = skid_q[1];
      skid_cnt_d  = skid_cnt_q - 2'd1;
      if (accept) begin
        skid_d[skid_cnt_d[0]] = dec;
        skid_cnt_d            = skid_cnt_q;
      end
    end else if (out_free) begin
      if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d[skid_cnt_q[0]] = dec;
      skid_cnt_d            = skid_cnt_q + 2'd1;
    end
    in_ready_d = (skid_cnt_d != 2'd2);
  end

  // State registers; reset empties both skid entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skid_q[0]   <= '0;
      skid_q[1]   <= '0;
      skid_cnt_q  <= 2'd0;
      in_ready_q  <= 1'b1;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      skid_q      <= skid_d;
      skid_cnt_q  <= skid_cnt_d;
      in_ready_q  <= in_ready_d;
    end
  end
`else
  assign in_ready = (~out_valid_q | out_ready) & ~flush & ~rst;
  assign accept   = in_valid & in_ready;

  // Single output register: load on accept, drop valid after a drain.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_d       = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign flag      = out_q.flag;
  assign oper      = out_q.oper;
  assign rega      = out_q.rega;
  assign regb      = out_q.regb;
  assign intermed  = out_q.intermed;
  assign mem_op    = out_q.mem_op;
  assign mem_addr  = out_q.mem_addr;
  assign illegal   = out_q.illegal;
  assign out_tag   = out_q.tag;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// tb/tb_instr_decode_pipe.sv - scoreboard bench for instr_decode_pipe
module tb_instr_decode_pipe;

  localparam int INSTR_W = 32;
  localparam int REG_W   = 6;
  localparam int IMM_W   = 16;
  localparam int MADDR_W = 10;
  localparam int TAG_W   = 8;
`ifdef DECODE_SKID_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 0;
`endif

  logic               clk = 1'b0;
  logic               rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [TAG_W-1:0]   in_tag, out_tag;
  logic [1:0]         flag, mem_op;
  logic [3:0]         oper;
  logic [REG_W-1:0]   rega, regb;
  logic [IMM_W-1:0]   intermed;
  logic [MADDR_W-1:0] mem_addr;
  logic               illegal;

  always #5 clk = ~clk;

  instr_decode_pipe #(
    .INSTR_W(INSTR_W), .REG_W(REG_W), .IMM_W(IMM_W), .MADDR_W(MADDR_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .flag(flag), .oper(oper), .rega(rega), .regb(regb), .intermed(intermed),
    .mem_op(mem_op), .mem_addr(mem_addr), .illegal(illegal), .out_tag(out_tag)
  );

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  flag;
    logic [3:0]  oper;
    logic [5:0]  rega;
    logic [5:0]  regb;
    logic [15:0] imm;
    logic [1:0]  mop;
    logic [9:0]  maddr;
    logic        ill;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic [7:0] tag;
  } exp_t;

  vec_t       vec [12];
  exp_t       sb [$];
  int         total = 0;
  int         bad = 0;
  int         n_out = 0;
  int         cur_idx = 0;
  logic [7:0] next_tag;

  function automatic logic [54:0] pack_exp(input vec_t v, input logic [7:0] tag);
    return {v.flag, v.oper, v.rega, v.regb, v.imm, v.mop, v.maddr, v.ill, tag};
  endfunction

  function automatic logic [54:0] dut_fields();
    return {flag, oper, rega, regb, intermed, mem_op, mem_addr, illegal, out_tag};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int idx, output int waits);
    in_valid = 1'b1;
    in_instr = vec[idx].instr;
    in_tag   = next_tag;
    cur_idx  = idx;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 40) begin
        total++;
        bad++;
        $display("FAIL send_timeout: vector %0d got in_ready=0 expected 1", idx);
        break;
      end
    end
    next_tag++;
    step();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 30 && sb.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    chk("drain_empty", sb.size(), 0);
    step();
  endtask

  // Acceptance observer: queue the hand-computed result of each accepted word.
  always @(negedge clk) begin
    if (!rst && !flush && in_valid && in_ready) sb.push_back('{vec[cur_idx], in_tag});
  end

  // Output monitor: every output transfer must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush) begin
      sb.delete();
    end else if (out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got fields=%0h expected no output", dut_fields());
      end else begin
        e = sb.pop_front();
        n_out++;
        if (dut_fields() !== pack_exp(e.v, e.tag)) begin
          bad++;
          $display("FAIL result instr=%08h: got flag=%0d oper=%0d rega=%0h regb=%0h imm=%0h mop=%0d maddr=%0h ill=%0b tag=%0h expected flag=%0d oper=%0d rega=%0h regb=%0h imm=%0h mop=%0d maddr=%0h ill=%0b tag=%0h",
                   e.v.instr, flag, oper, rega, regb, intermed, mem_op, mem_addr, illegal, out_tag,
                   e.v.flag, e.v.oper, e.v.rega, e.v.regb, e.v.imm, e.v.mop, e.v.maddr, e.v.ill, e.tag);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, ws, n0, acc, nxt;
    logic [7:0] tag6;

    //          instr         flag  oper  rega   regb   imm       mop   maddr    ill
    vec[0]  = '{32'h5431C000, 2'd1, 4'd5, 6'h03, 6'h07, 16'h0000, 2'd0, 10'h000, 1'b0};
    vec[1]  = '{32'h8C9BEEF0, 2'd2, 4'd3, 6'h09, 6'h00, 16'hBEEF, 2'd0, 10'h000, 1'b0};
    vec[2]  = '{32'hD1155000, 2'd3, 4'd0, 6'h04, 6'h00, 16'h0000, 2'd1, 10'h155, 1'b0};
    vec[3]  = '{32'hFAA848D0, 2'd3, 4'd0, 6'h00, 6'h00, 16'h1234, 2'd3, 10'h2AA, 1'b0};
    vec[4]  = '{32'h9C000000, 2'd2, 4'd7, 6'h00, 6'h00, 16'h0000, 2'd0, 10'h000, 1'b1};
    vec[5]  = '{32'h00000000, 2'd0, 4'd0, 6'h00, 6'h00, 16'h0000, 2'd0, 10'h000, 1'b0};
    vec[6]  = '{32'h8AA54000, 2'd2, 4'd2, 6'h2A, 6'h15, 16'h0000, 2'd0, 10'h000, 1'b0};
    vec[7]  = '{32'hEFFFFFFF, 2'd3, 4'd0, 6'h3F, 6'h00, 16'h0000, 2'd2, 10'h3FF, 1'b0};
    vec[8]  = '{32'hC007FFFC, 2'd3, 4'd0, 6'h00, 6'h00, 16'hFFFF, 2'd0, 10'h001, 1'b0};
    vec[9]  = '{32'hBFFFFFFF, 2'd2, 4'hF, 6'h00, 6'h00, 16'h0000, 2'd0, 10'h000, 1'b1};
    vec[10] = '{32'h3FFFFFFF, 2'd0, 4'd0, 6'h00, 6'h00, 16'h0000, 2'd0, 10'h000, 1'b0};
    vec[11] = '{32'h7FFFFFFF, 2'd1, 4'hF, 6'h3F, 6'h3F, 16'h0000, 2'd0, 10'h000, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0;
    out_ready = 1'b1; next_tag = 8'h11;

    // reset held three cycles
    repeat (3) begin
      @(negedge clk);
      chk("reset_state", {out_valid, in_ready, dut_fields()}, 64'd0);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);
    step();

    // single ALU reg-reg, one-cycle latency
    n0 = n_out;
    send(0, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    #1;
    chk("latency_pop", n_out - n0, 1);
    step();

    // reg-imm, load, store-imm back to back
    n0 = n_out; ws = 0;
    send(1, w); ws += w;
    send(2, w); ws += w;
    send(3, w); ws += w;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("b2b_waits", ws, 0);
    chk("b2b_count", n_out - n0, 3);
    step();

    // illegal then NOP
    send(4, w);
    send(5, w);
    drain();

    // backpressure
    out_ready = 1'b0;
    send(6, w);
    tag6 = next_tag - 8'd1;
    nxt = 7; acc = 0;
    in_valid = 1'b1; in_instr = vec[nxt].instr; in_tag = next_tag; cur_idx = nxt;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_out", {out_valid, dut_fields()}, {1'b1, pack_exp(vec[6], tag6)});
      if (k == 3) chk("bp_ready_low", in_ready, 0);
      if (in_ready) begin
        acc++; next_tag++; nxt++;
        step();
        in_instr = vec[nxt].instr; in_tag = next_tag; cur_idx = nxt;
      end else begin
        step();
      end
    end
    chk("bp_accepted", acc, EXP_ACC);
    out_ready = 1'b1;
    for (int i = nxt; i < 12; i++) send(i, w);
    drain();

    // flush after a stall, with both handshakes otherwise ready
    out_ready = 1'b0;
    send(9, w);
    in_valid = 1'b0;
    @(negedge clk);
    step();
    in_valid = 1'b1; in_instr = vec[10].instr; in_tag = next_tag; cur_idx = 10;
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_blocks_input", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_clears_valid", out_valid, 0);
    step();
    n0 = n_out;
    send(11, w);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("after_flush_emits", n_out - n0, 1);
    step();

    // reset mid-stream
    out_ready = 1'b0;
    send(0, w);
    in_valid = 1'b1; in_instr = vec[1].instr; in_tag = next_tag; cur_idx = 1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_blocks_input", in_ready, 0);
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_clears_out", {out_valid, dut_fields()}, 64'd0);
    chk("ready_after_midrst", in_ready, 1);
    step();
    send(3, w);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
